// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Running score and best score for the goose-run game.
//                A prescaler awards +1 point every PTS_DIV clocks while a run
//                is in progress. Each bonus pulse adds BONUS points. The score
//                saturates at SCORE_MAX. When the game ends, the high score is
//                updated and the new-record flag is raised.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : system clock, rising edge
//    rst_n        : asynchronous active-low reset
//    start_i      : 1-cycle pulse, begin a new run (IDLE/OVER only)
//    game_over_i  : 1-cycle pulse, end the current run (RUN only)
//    bonus_i      : 1-cycle pulse, add BONUS points (RUN only)
//    score_o      : current run score, registered
//    score_hi_o   : best score since reset, registered
//    new_record_o : set when the last run beat the previous best
//    running_o    : 1 while a run is in progress
// ============================================================================
module score_keeper #(
    parameter int unsigned PTS_DIV   = 1_250_000,
    parameter int unsigned BONUS     = 10,
    parameter int unsigned SCORE_MAX = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        game_over_i,
    input  logic        bonus_i,
    output logic [31:0] score_o,
    output logic [31:0] score_hi_o,
    output logic        new_record_o,
    output logic        running_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_RUN     = 2'd1;
    localparam logic [1:0]  ST_OVER    = 2'd2;

    localparam logic [23:0] PRESC_LAST = 24'(PTS_DIV - 1);
    localparam logic [32:0] BONUS_W    = 33'(BONUS);
    localparam logic [32:0] MAX_W      = 33'(SCORE_MAX);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [31:0] score_q, score_d;
    logic [31:0] hi_q,    hi_d;
    logic        nr_q,    nr_d;

    logic        tick_w;
    logic [32:0] sum_w;
    logic [31:0] clamped_w;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // game_over has priority over start in RUN, because start is ignored there.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (game_over_i) begin
                    state_d = ST_OVER;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        running_o = (state_q == ST_RUN);
    end

    // ------------------------------------------------------------------------
    // Score arithmetic
    // The sum uses one extra bit, so a bonus near the ceiling cannot wrap
    // before the clamp is applied.
    // ------------------------------------------------------------------------
    always_comb begin
        tick_w    = (presc_q == PRESC_LAST);
        sum_w     = {1'b0, score_q}
                  + (tick_w  ? 33'd1   : 33'd0)
                  + (bonus_i ? BONUS_W : 33'd0);
        clamped_w = (sum_w > MAX_W) ? MAX_W[31:0] : sum_w[31:0];
    end

    // ------------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        score_d = score_q;
        hi_d    = hi_q;
        nr_d    = nr_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_i) begin
                    presc_d = 24'd0;
                    score_d = 32'd0;
                    nr_d    = 1'b0;
                end
            end
            ST_RUN: begin
                // The prescaler keeps counting at saturation. Only the score holds.
                presc_d = tick_w ? 24'd0 : (presc_q + 24'd1);
                score_d = clamped_w;
                // The comparison uses the post-update score. A tie does not
                // count as a new record.
                if (game_over_i && (clamped_w > hi_q)) begin
                    hi_d = clamped_w;
                    nr_d = 1'b1;
                end
            end
            default: begin
                presc_d = 24'd0;
                score_d = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 24'd0;
            score_q <= 32'd0;
            hi_q    <= 32'd0;
            nr_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            score_q <= score_d;
            hi_q    <= hi_d;
            nr_q    <= nr_d;
        end
    end

    assign score_o      = score_q;
    assign score_hi_o   = hi_q;
    assign new_record_o = nr_q;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Directed, table-driven bench for score_keeper
//                (PTS_DIV=4, BONUS=10, SCORE_MAX=9999).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        game_over_i;
    logic        bonus_i;
    logic [31:0] score_o;
    logic [31:0] score_hi_o;
    logic        new_record_o;
    logic        running_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit st;
        bit go;
        bit bn;
        int reps;
        int e_score;
        int e_hi;
        bit e_nr;
        bit e_run;
    } vec_t;

    vec_t vecs[22];

    score_keeper #(
        .PTS_DIV   (4),
        .BONUS     (10),
        .SCORE_MAX (9999)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .game_over_i  (game_over_i),
        .bonus_i      (bonus_i),
        .score_o      (score_o),
        .score_hi_o   (score_hi_o),
        .new_record_o (new_record_o),
        .running_o    (running_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int s, input int h, input bit nr, input bit run);
        chk({tag, ".score"},      score_o,               32'(s));
        chk({tag, ".score_hi"},   score_hi_o,            32'(h));
        chk({tag, ".new_record"}, {31'd0, new_record_o}, {31'd0, nr});
        chk({tag, ".running"},    {31'd0, running_o},    {31'd0, run});
    endtask

    // Hold the inputs for n rising edges, then sample 1 time unit after the last edge.
    task automatic cyc(input bit s, input bit g, input bit b, input int n);
        for (int k = 0; k < n; k++) begin
            start_i     = s;
            game_over_i = g;
            bonus_i     = b;
            @(posedge clk);
            #1;
        end
        start_i     = 1'b0;
        game_over_i = 1'b0;
        bonus_i     = 1'b0;
    endtask

    initial begin
        //            st go bn reps score  hi  nr run
        vecs[0]  = '{1, 0, 0, 1,   0,    0,  0, 1};  // start
        vecs[1]  = '{0, 0, 0, 20,  5,    0,  0, 1};  // 20 clks -> 5
        vecs[2]  = '{0, 0, 0, 3,   5,    0,  0, 1};  // prescaler now at 3
        vecs[3]  = '{0, 0, 1, 1,   16,   0,  0, 1};  // tick+bonus -> +11
        vecs[4]  = '{0, 0, 1, 1,   26,   0,  0, 1};
        vecs[5]  = '{0, 0, 0, 3,   27,   0,  0, 1};
        vecs[6]  = '{0, 0, 1, 1,   37,   0,  0, 1};
        vecs[7]  = '{0, 1, 0, 1,   37,   37, 1, 0};  // game over, record
        vecs[8]  = '{0, 0, 1, 2,   37,   37, 1, 0};  // bonus ignored in OVER
        vecs[9]  = '{0, 1, 0, 1,   37,   37, 1, 0};  // game_over ignored in OVER
        vecs[10] = '{1, 0, 0, 1,   0,    37, 0, 1};  // run 2
        vecs[11] = '{0, 0, 1, 3,   30,   37, 0, 1};
        vecs[12] = '{0, 0, 0, 25,  37,   37, 0, 1};
        vecs[13] = '{0, 1, 0, 1,   37,   37, 0, 0};  // tie, no record
        vecs[14] = '{1, 0, 0, 1,   0,    37, 0, 1};  // run 3
        vecs[15] = '{0, 0, 1, 2,   20,   37, 0, 1};
        vecs[16] = '{0, 1, 0, 1,   20,   37, 0, 0};  // lower, no record
        vecs[17] = '{1, 0, 0, 1,   0,    37, 0, 1};  // run 4
        vecs[18] = '{0, 0, 0, 2,   0,    37, 0, 1};
        vecs[19] = '{1, 0, 0, 1,   0,    37, 0, 1};  // start ignored in RUN
        vecs[20] = '{0, 0, 0, 1,   1,    37, 0, 1};  // prescaler was not cleared
        vecs[21] = '{1, 1, 0, 1,   1,    37, 0, 0};  // start+game_over -> OVER

        rst_n       = 1'b0;
        start_i     = 1'b0;
        game_over_i = 1'b0;
        bonus_i     = 1'b0;
        #12;
        chk_all("reset", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset", 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].st, vecs[i].go, vecs[i].bn, vecs[i].reps);
            chk_all($sformatf("vec%0d", i), vecs[i].e_score, vecs[i].e_hi,
                    vecs[i].e_nr, vecs[i].e_run);
        end

        // Saturation: 975 bonus cycles give 9750 + 243 ticks = 9993, prescaler=3.
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b1, 975);
        chk("sat.9993", score_o, 32'd9993);
        cyc(1'b0, 1'b0, 1'b0, 1);
        chk("sat.9994", score_o, 32'd9994);
        cyc(1'b0, 1'b0, 1'b0, 4);
        chk("sat.9995", score_o, 32'd9995);
        cyc(1'b0, 1'b0, 1'b1, 1);
        chk("sat.bonus_clamp", score_o, 32'd9999);
        cyc(1'b0, 1'b0, 1'b0, 9);
        chk("sat.hold", score_o, 32'd9999);
        cyc(1'b0, 1'b0, 1'b1, 1);
        chk("sat.bonus_hold", score_o, 32'd9999);
        cyc(1'b0, 1'b1, 1'b0, 1);
        chk_all("sat.over", 9999, 9999, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b1, 1);
        chk_all("prerst", 10, 9999, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        chk_all("async_rst", 0, 0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 2);
        chk_all("idle_after_rst", 0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
